// File: rtl/act_dram_compressor.sv
// Zero-skipping compressor feeding the activation RAM: dense DRAM beats in, LANES-wide sparse packets out.
// Optional macro DENSE_BYPASS_EN adds a dense_mode port that emits every element uncompressed.
module act_dram_compressor #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned LANES  = 4,
  parameter int unsigned IDX_W  = 4,
  parameter int unsigned CH_W   = 6,
  parameter int unsigned CNT_W  = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*DATA_W-1:0] in_data,
  input  logic [CH_W-1:0]         in_channel,
  input  logic                    in_last,
`ifdef DENSE_BYPASS_EN
  input  logic                    dense_mode,
`endif
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*DATA_W-1:0] out_data,
  output logic [LANES*IDX_W-1:0]  out_indices,
  output logic [LANES-1:0]        out_lane_valid,
  output logic [CH_W-1:0]         out_channel,
  output logic                    out_last,
  output logic [CNT_W-1:0]        ch_count,
  output logic                    ch_count_valid
);

  localparam int unsigned DEPTH = 2 * LANES;
  localparam int unsigned SC_W  = $clog2(DEPTH + 1);
  localparam int unsigned SP_W  = $clog2(DEPTH);
  localparam int unsigned NC_W  = $clog2(LANES + 1);
  localparam logic [IDX_W-1:0] MAX_RUN = '1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {ACCEPT, FLUSH, DONE} state_t;

  state_t              state;
  logic [DATA_W-1:0]   stg_val [DEPTH];
  logic [IDX_W-1:0]    stg_idx [DEPTH];
  logic [SC_W-1:0]     stg_cnt;
  logic [IDX_W-1:0]    zrun;
  logic [CNT_W-1:0]    ent_cnt;
  logic                first;
  logic [CH_W-1:0]     ch_tag;
  logic                dense_cur;

  logic                out_free, accept, pop_full, pop_last;
  logic [DATA_W-1:0]   nv [DEPTH];
  logic [IDX_W-1:0]    ni [DEPTH];
  logic [SC_W-1:0]     wr;
  logic [NC_W-1:0]     n_emit;
  logic [IDX_W-1:0]    z;
  logic [DATA_W-1:0]   x;
  logic [CNT_W:0]      ent_sum;
  logic [LANES-1:0]    ld_mask;
  logic [LANES*DATA_W-1:0] ld_data;
  logic [LANES*IDX_W-1:0]  ld_idx;

`ifdef DENSE_BYPASS_EN
  logic dense_q;
  assign dense_cur = first ? dense_mode : dense_q;
`else
  assign dense_cur = 1'b0;
`endif

  assign in_ready = !rst && (state == ACCEPT) && (stg_cnt <= SC_W'(LANES));

  // Staging update: pop LANES from the head, then append this beat's compressed entries.
  always_comb begin
    out_free = !out_valid || out_ready;
    accept   = in_valid && in_ready;
    pop_full = out_free && (((state == ACCEPT) && (stg_cnt >= SC_W'(LANES))) ||
                            ((state == FLUSH)  && (stg_cnt >  SC_W'(LANES))));
    pop_last = out_free && (state == FLUSH) && (stg_cnt <= SC_W'(LANES));
    for (int j = 0; j < DEPTH; j++) begin
      nv[j] = stg_val[j];
      ni[j] = stg_idx[j];
    end
    wr = stg_cnt;
    if (pop_full) begin
      for (int j = 0; j < LANES; j++) begin
        nv[j]         = stg_val[j+LANES];
        ni[j]         = stg_idx[j+LANES];
        nv[j+LANES]   = '0;
        ni[j+LANES]   = '0;
      end
      wr = stg_cnt - SC_W'(LANES);
    end
    if (pop_last) wr = '0;
    z      = zrun;
    n_emit = '0;
    x      = '0;
    if (accept) begin
      for (int i = 0; i < LANES; i++) begin
        x = in_data[i*DATA_W +: DATA_W];
        if (dense_cur || (x != '0) || (z == MAX_RUN)) begin
          nv[SP_W'(wr)] = x;
          ni[SP_W'(wr)] = dense_cur ? '0 : z;
          wr     = wr + SC_W'(1);
          n_emit = n_emit + NC_W'(1);
          z      = '0;
        end else begin
          z = z + IDX_W'(1);
        end
      end
    end
    ent_sum = {1'b0, ent_cnt} + (CNT_W+1)'(n_emit);
    for (int i = 0; i < LANES; i++) begin
      ld_mask[i] = pop_full || (SC_W'(i) < stg_cnt);
      ld_data[i*DATA_W +: DATA_W] = ld_mask[i] ? stg_val[i] : '0;
      ld_idx[i*IDX_W +: IDX_W]    = ld_mask[i] ? stg_idx[i] : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ACCEPT;
      stg_cnt        <= '0;
      zrun           <= '0;
      ent_cnt        <= '0;
      first          <= 1'b1;
      ch_tag         <= '0;
      out_valid      <= 1'b0;
      out_last       <= 1'b0;
      out_data       <= '0;
      out_indices    <= '0;
      out_lane_valid <= '0;
      out_channel    <= '0;
      ch_count       <= '0;
      ch_count_valid <= 1'b0;
      for (int j = 0; j < DEPTH; j++) begin
        stg_val[j] <= '0;
        stg_idx[j] <= '0;
      end
`ifdef DENSE_BYPASS_EN
      dense_q        <= 1'b0;
`endif
    end else begin
      ch_count_valid <= 1'b0;
      stg_cnt        <= wr;
      zrun           <= (accept && in_last) ? '0 : z;
      for (int j = 0; j < DEPTH; j++) begin
        stg_val[j] <= nv[j];
        stg_idx[j] <= ni[j];
      end
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (accept) begin
        if (first) begin
          ch_tag  <= in_channel;
`ifdef DENSE_BYPASS_EN
          dense_q <= dense_mode;
`endif
        end
        first   <= 1'b0;
        ent_cnt <= ent_sum[CNT_W] ? CNT_MAX : ent_sum[CNT_W-1:0];
        if (in_last) state <= FLUSH;
      end
      if (pop_full || pop_last) begin
        out_valid      <= 1'b1;
        out_last       <= pop_last;
        out_channel    <= ch_tag;
        out_data       <= ld_data;
        out_indices    <= ld_idx;
        out_lane_valid <= ld_mask;
        if (pop_last) state <= DONE;
      end
      // Final packet taken downstream: report the channel and rearm for the next one.
      if ((state == DONE) && out_valid && out_ready) begin
        ch_count_valid <= 1'b1;
        ch_count       <= ent_cnt;
        ent_cnt        <= '0;
        zrun           <= '0;
        first          <= 1'b1;
        state          <= ACCEPT;
      end
    end
  end

endmodule

// File: tb/tb_act_dram_compressor.sv
// Directed bench for act_dram_compressor: hand-computed packets, channel counts, backpressure and reset.
module tb_act_dram_compressor;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_last;
  logic [63:0] in_data;
  logic [5:0]  in_channel;
  logic        out_valid, out_ready, out_last;
  logic [63:0] out_data;
  logic [15:0] out_indices;
  logic [3:0]  out_lane_valid;
  logic [5:0]  out_channel;
  logic [9:0]  ch_count;
  logic        ch_count_valid;
`ifdef DENSE_BYPASS_EN
  logic        dense_mode = 1'b0;
`endif

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [63:0] d;
    logic [15:0] i;
    logic [3:0]  m;
    logic [5:0]  c;
    logic        l;
  } pkt_t;
  pkt_t        pq[$];
  logic [9:0]  cq[$];

  act_dram_compressor dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_channel(in_channel), .in_last(in_last),
`ifdef DENSE_BYPASS_EN
    .dense_mode(dense_mode),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_indices(out_indices), .out_lane_valid(out_lane_valid),
    .out_channel(out_channel), .out_last(out_last),
    .ch_count(ch_count), .ch_count_valid(ch_count_valid)
  );

  always #5 clk = ~clk;

  // Capture handshakes and count pulses mid-cycle, after the negedge-driven inputs settle.
  always @(negedge clk) begin
    #2;
    if (!rst && out_valid && out_ready)
      pq.push_back('{d: out_data, i: out_indices, m: out_lane_valid, c: out_channel, l: out_last});
    if (!rst && ch_count_valid) cq.push_back(ch_count);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] beat(input int a, input int b, input int c, input int d);
    return {16'(d), 16'(c), 16'(b), 16'(a)};
  endfunction

  task automatic send_beat(input logic [63:0] d, input logic [5:0] ch, input logic last);
    int waited = 0;
    in_data = d; in_channel = ch; in_last = last; in_valid = 1'b1;
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 50) chk("accept_timeout", 64'(in_ready), 64'(1));
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic exp_pkt(input string tag, input logic [63:0] d, input logic [15:0] ix,
                         input logic [3:0] m, input logic [5:0] c, input logic l);
    int n = 0;
    pkt_t p;
    while (pq.size() == 0 && n < 300) begin
      @(negedge clk); #3; n++;
    end
    if (pq.size() == 0) begin
      chk({tag, "_timeout"}, 64'(0), 64'(1));
      return;
    end
    p = pq.pop_front();
    chk({tag, "_data"}, p.d, d);
    chk({tag, "_idx"},  64'(p.i), 64'(ix));
    chk({tag, "_mask"}, 64'(p.m), 64'(m));
    chk({tag, "_ch"},   64'(p.c), 64'(c));
    chk({tag, "_last"}, 64'(p.l), 64'(l));
  endtask

  task automatic exp_cnt(input string tag, input logic [9:0] e);
    int n = 0;
    logic [9:0] v;
    while (cq.size() == 0 && n < 300) begin
      @(negedge clk); #3; n++;
    end
    if (cq.size() == 0) begin
      chk({tag, "_timeout"}, 64'(0), 64'(1));
      return;
    end
    v = cq.pop_front();
    chk(tag, 64'(v), 64'(e));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0; in_channel = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_in_ready",   64'(in_ready), 64'(0));
    chk("rst_out_valid",  64'(out_valid), 64'(0));
    chk("rst_out_last",   64'(out_last), 64'(0));
    chk("rst_ccv",        64'(ch_count_valid), 64'(0));
    chk("rst_ch_count",   64'(ch_count), 64'(0));
    chk("rst_lane_valid", 64'(out_lane_valid), 64'(0));
    chk("rst_data",       out_data, 64'(0));
    rst = 1'b0;
    #1 chk("post_rst_in_ready", 64'(in_ready), 64'(1));
    @(negedge clk);

    // [5,0,0,7] last: entries (5,0),(7,2)
    send_beat(beat(5, 0, 0, 7), 6'd1, 1'b1);
    exp_pkt("t1", 64'h0000_0000_0007_0005, 16'h0020, 4'b0011, 6'd1, 1'b1);
    exp_cnt("t1_count", 10'd2);

    // 20 zeros then 3: max-run zero entry (0,15) at the 16th zero, then (3,4)
    for (int b = 0; b < 5; b++) send_beat(beat(0, 0, 0, 0), 6'd3, 1'b0);
    send_beat(beat(3, 0, 0, 0), 6'd63, 1'b1);
    exp_pkt("t2", 64'h0000_0000_0003_0000, 16'h004F, 4'b0011, 6'd3, 1'b1);
    exp_cnt("t2_count", 10'd2);

    // two dense non-zero beats
    send_beat(beat(1, 2, 3, 4), 6'd5, 1'b0);
    send_beat(beat(5, 6, 7, 8), 6'd5, 1'b1);
    exp_pkt("t3a", 64'h0004_0003_0002_0001, 16'h0000, 4'b1111, 6'd5, 1'b0);
    exp_pkt("t3b", 64'h0008_0007_0006_0005, 16'h0000, 4'b1111, 6'd5, 1'b1);
    exp_cnt("t3_count", 10'd8);

    // all-zero channel: empty final packet
    send_beat(beat(0, 0, 0, 0), 6'd7, 1'b1);
    exp_pkt("t4", 64'h0, 16'h0000, 4'b0000, 6'd7, 1'b1);
    exp_cnt("t4_count", 10'd0);

    // backpressure: out_ready low for 6 cycles while 4 beats are offered
    out_ready = 1'b0;
    fork
      begin
        send_beat(beat(1, 2, 3, 4),     6'd9, 1'b0);
        send_beat(beat(5, 6, 7, 8),     6'd9, 1'b0);
        send_beat(beat(9, 10, 11, 12),  6'd9, 1'b0);
        send_beat(beat(13, 14, 15, 16), 6'd9, 1'b1);
      end
      begin
        repeat (6) @(negedge clk);
        chk("bp_in_ready_low", 64'(in_ready), 64'(0));
        chk("bp_no_handshake", 64'(pq.size()), 64'(0));
        out_ready = 1'b1;
      end
    join
    exp_pkt("bp0", 64'h0004_0003_0002_0001, 16'h0000, 4'b1111, 6'd9, 1'b0);
    exp_pkt("bp1", 64'h0008_0007_0006_0005, 16'h0000, 4'b1111, 6'd9, 1'b0);
    exp_pkt("bp2", 64'h000C_000B_000A_0009, 16'h0000, 4'b1111, 6'd9, 1'b0);
    exp_pkt("bp3", 64'h0010_000F_000E_000D, 16'h0000, 4'b1111, 6'd9, 1'b1);
    exp_cnt("bp_count", 10'd16);

    // reset while in FLUSH with 3 staged entries and a full output register
    out_ready = 1'b0;
    send_beat(beat(1, 2, 3, 4), 6'd11, 1'b0);
    send_beat(beat(5, 6, 7, 0), 6'd11, 1'b1);
    repeat (2) @(negedge clk);
    chk("mid_pre_out_valid", 64'(out_valid), 64'(1));
    chk("mid_pre_in_ready",  64'(in_ready), 64'(0));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_out_valid",  64'(out_valid), 64'(0));
    chk("mid_lane_valid", 64'(out_lane_valid), 64'(0));
    chk("mid_in_ready",   64'(in_ready), 64'(1));
    out_ready = 1'b1;
    repeat (5) @(negedge clk);
    chk("mid_no_residual", 64'(pq.size()), 64'(0));
    send_beat(beat(9, 0, 0, 0), 6'd12, 1'b1);
    exp_pkt("t6", 64'h0000_0000_0000_0009, 16'h0000, 4'b0001, 6'd12, 1'b1);
    exp_cnt("t6_count", 10'd1);
    repeat (5) @(negedge clk);
    chk("t6_no_extra_pkt", 64'(pq.size()), 64'(0));
    chk("t6_no_extra_cnt", 64'(cq.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
